// File: rtl/bt_uart_pkg.sv
// Shared definitions for the Bluetooth UART receiver and transmitter:
// the state encoding, the default bit period and the frame length.
package bt_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 5208;
    localparam int FRAME_BITS       = 8;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE      = 3'd0;
    localparam rx_state_t ST_START     = 3'd1;
    localparam rx_state_t ST_DATA      = 3'd2;
    localparam rx_state_t ST_PARITY    = 3'd3;
    localparam rx_state_t ST_STOP      = 3'd4;
    localparam rx_state_t ST_WAIT_IDLE = 3'd5;

endpackage

// File: rtl/bt_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a
// configurable reset value so an idle-high line looks idle out of reset.
module bt_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver for the Bluetooth module link (LSB first, idle high).
// Define BT_RX_PARITY_EN to expect an even-parity bit after the data bits.
module bt_uart_rx
    import bt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST      = BW'(FRAME_BITS - 1);

    logic rxd_s;

    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic [1:0]            prime_q, prime_d;
    logic                  armed_q, armed_d;
`ifdef BT_RX_PARITY_EN
    logic                  perr_q, perr_d;
    logic                  par_bad_q, par_bad_d;
`endif

    bt_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rxd),
        .q_o  (rxd_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef BT_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        // Starts are only accepted once the synchronizer holds real line
        // samples that show idle, so a frame caught mid-way by reset is ignored.
        prime_d = {prime_q[0], 1'b1};
        armed_d = armed_q | (prime_q[1] & rxd_s);

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !rxd_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[FRAME_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef BT_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef BT_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rxd_s ^ (^shift_q);
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef BT_RX_PARITY_EN
                        perr_d  = par_bad_q;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            prime_q <= 2'b00;
            armed_q <= 1'b0;
`ifdef BT_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            prime_q <= prime_d;
            armed_q <= armed_d;
`ifdef BT_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef BT_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bt_uart_rx.sv
// Self-checking bench for bt_uart_rx: directed frames plus random traffic,
// scored against an event-level model of what each sent frame should produce.
module tb_bt_uart_rx;

    localparam int CPB = 16;
`ifdef BT_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Receiver decides at the middle of the stop bit, plus synchronizer slack.
    localparam int LAT_NOM   = (CPB * 19) / 2 + PAR_BITS * CPB;
    localparam int FRAME_LEN = (10 + PAR_BITS) * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    always #5 clk = ~clk;

    bt_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    typedef struct {
        int         kind;   // 0 = valid, 1 = frame error
        logic [7:0] d;
        int         cyc;
        logic       perr;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    ev_t        mon_e;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (valid === 1'b1 || frame_err === 1'b1)) begin
            mon_e.kind = (frame_err === 1'b1) ? 1 : 0;
            mon_e.d    = data;
            mon_e.cyc  = cyc;
            mon_e.perr = parity_err;
            obs_q.push_back(mon_e);
            check_val("valid_ferr_exclusive", {31'b0, valid & frame_err}, 32'd0);
        end
    end

    task automatic hold(input logic level, input int n);
        rxd = level;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        hold(b, CPB);
    endtask

    // Sends one frame and records the single event the receiver owes for it.
    task automatic send_raw(input logic [7:0] b, input logic stop_b, input logic flip);
        ev_t e;
        e.cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef BT_RX_PARITY_EN
        send_bit((^b) ^ flip);
`endif
        send_bit(stop_b);
        if (stop_b) last_good = b;
        e.kind = stop_b ? 0 : 1;
        e.d    = last_good;
`ifdef BT_RX_PARITY_EN
        e.perr = stop_b & flip;
`else
        e.perr = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string tag);
        int lat;
        check_val({tag, " event_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            lat = obs_q[i].cyc - exp_q[i].cyc;
            $display("%s: event %0d kind=%0d data=%02h perr=%0b latency=%0d clk",
                     tag, i, obs_q[i].kind, obs_q[i].d, obs_q[i].perr, lat);
            check_val({tag, " kind"}, obs_q[i].kind, exp_q[i].kind);
            check_val({tag, " data"}, obs_q[i].d, exp_q[i].d);
            check_val({tag, " parity_err"}, obs_q[i].perr, exp_q[i].perr);
            check_val({tag, " latency_in_window"},
                      {31'b0, (lat >= LAT_NOM + 2 && lat <= LAT_NOM + 4)}, 32'd1);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         gap;

        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset data", data, 8'h00);
        check_val("reset valid", valid, 1'b0);
        check_val("reset frame_err", frame_err, 1'b0);
        check_val("reset parity_err", parity_err, 1'b0);
        check_val("reset busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b1, 2 * CPB);

        // Single clean frame.
        send_raw(8'hE3, 1'b1, 1'b0);
        @(negedge clk);
        check_val("e3 busy_after_stop", busy, 1'b0);
        check_val("e3 data", data, 8'hE3);
        hold(1'b1, CPB);
        compare_events("e3");

        // Back-to-back frames with no idle gap.
        send_raw(8'h55, 1'b1, 1'b0);
        send_raw(8'hAA, 1'b1, 1'b0);
        hold(1'b1, CPB);
        if (obs_q.size() >= 2)
            check_val("b2b spacing", obs_q[1].cyc - obs_q[0].cyc, FRAME_LEN);
        compare_events("b2b");

        // Short low glitch must be rejected.
        hold(1'b0, 5);
        rxd = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check_val("glitch busy_cleared", busy, 1'b0);
        hold(1'b1, 2 * CPB);
        compare_events("glitch");

        // Bad stop bit followed by a long break, then a fresh frame.
        send_raw(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 40 * CPB);
        check_val("break data_kept", data, last_good);
        check_val("break busy", busy, 1'b1);
        hold(1'b1, 2 * CPB);
        send_raw(8'h81, 1'b1, 1'b0);
        hold(1'b1, CPB);
        check_val("break recovery data", data, 8'h81);
        compare_events("break");

        // Reset during data bit 4 of 0xF0.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        hold(1'b1, 8);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midreset data", data, 8'h00);
        check_val("midreset busy", busy, 1'b0);
        check_val("midreset valid", valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_good = 8'h00;
        hold(1'b1, 4 * CPB);
        hold(1'b1, CPB);
        send_raw(8'h0F, 1'b1, 1'b0);
        hold(1'b1, CPB);
        compare_events("reset");

`ifdef BT_RX_PARITY_EN
        send_raw(8'h07, 1'b1, 1'b1);
        send_raw(8'h07, 1'b1, 1'b0);
        hold(1'b1, CPB);
        compare_events("parity");
`endif

        // Random traffic with random idle gaps (including none).
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 2)) * CPB;
            if ($urandom_range(0, 1) == 1) gap += int'($urandom_range(0, 7));
            hold(1'b1, gap);
            send_raw(b, 1'b1, 1'($urandom_range(0, 1)));
        end
        hold(1'b1, CPB);
        compare_events("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
